// File: rtl/vpu_modport.sv
// rtl/vpu_modport.sv - single-instruction vector processing unit
//
// Accepts one instruction at a time. It reads up to three 512-bit operands over
// the source ports, computes a lane-wise 32-bit integer result, and writes the
// result over the destination port. It then returns a completion tagged with
// the request's stream ID.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            instruction handshake
//   req_instr                      {opcode, src2, src1, src0, dst0}; field = {bank, addr}
//   req_stream_id                  tag returned with the completion
//   rsp_valid/rsp_ready            completion handshake
//   rsp_stream_id                  tag of the completed instruction
//   sK_req/rid/addr/reb/rlast      source read request (K = 0..2), reb active-low
//   sK_ack/rdata/rvalid            source read accept and data return
//   d0_req/wid/addr/web/wlast      destination write request, web active-low
//   d0_wdata, d0_ack               write data, write accept
module vpu_modport #(
  parameter int STREAM_ID_WIDTH     = 4,
  parameter int SRAM_BANK_CNT_LG2   = 3,
  parameter int SRAM_BANK_DEPTH_LG2 = 10,
  parameter int SRAM_DATA_WIDTH     = 512,
  parameter int OPCODE_WIDTH        = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [OPCODE_WIDTH+4*(SRAM_BANK_CNT_LG2+SRAM_BANK_DEPTH_LG2)-1:0] req_instr,
  input  logic [STREAM_ID_WIDTH-1:0]           req_stream_id,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [STREAM_ID_WIDTH-1:0]           rsp_stream_id,
  output logic                                 s0_req,
  output logic [SRAM_BANK_CNT_LG2-1:0]         s0_rid,
  output logic [SRAM_BANK_DEPTH_LG2-1:0]       s0_addr,
  output logic                                 s0_reb,
  output logic                                 s0_rlast,
  input  logic                                 s0_ack,
  input  logic [SRAM_DATA_WIDTH-1:0]           s0_rdata,
  input  logic                                 s0_rvalid,
  output logic                                 s1_req,
  output logic [SRAM_BANK_CNT_LG2-1:0]         s1_rid,
  output logic [SRAM_BANK_DEPTH_LG2-1:0]       s1_addr,
  output logic                                 s1_reb,
  output logic                                 s1_rlast,
  input  logic                                 s1_ack,
  input  logic [SRAM_DATA_WIDTH-1:0]           s1_rdata,
  input  logic                                 s1_rvalid,
  output logic                                 s2_req,
  output logic [SRAM_BANK_CNT_LG2-1:0]         s2_rid,
  output logic [SRAM_BANK_DEPTH_LG2-1:0]       s2_addr,
  output logic                                 s2_reb,
  output logic                                 s2_rlast,
  input  logic                                 s2_ack,
  input  logic [SRAM_DATA_WIDTH-1:0]           s2_rdata,
  input  logic                                 s2_rvalid,
  output logic                                 d0_req,
  output logic [SRAM_BANK_CNT_LG2-1:0]         d0_wid,
  output logic [SRAM_BANK_DEPTH_LG2-1:0]       d0_addr,
  output logic                                 d0_web,
  output logic                                 d0_wlast,
  output logic [SRAM_DATA_WIDTH-1:0]           d0_wdata,
  input  logic                                 d0_ack
);

  localparam int BW    = SRAM_BANK_CNT_LG2;
  localparam int AW    = SRAM_BANK_DEPTH_LG2;
  localparam int FW    = BW + AW;
  localparam int DW    = SRAM_DATA_WIDTH;
  localparam int IW    = OPCODE_WIDTH + 4 * FW;
  localparam int LANES = DW / 32;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_MAX  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_MIN  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD3 = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = OPCODE_WIDTH'(7);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_RESP} state_t;

  state_t                  state;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [FW-1:0]           dst_q;
  logic [2:0]              req_q;
  logic [2:0]              reb_q;
  logic [2:0]              rlast_q;
  logic [2:0]              wait_q;
  logic [BW-1:0]           rid_q  [3];
  logic [AW-1:0]           addr_q [3];
  logic [DW-1:0]           opnd_q [3];

  logic [OPCODE_WIDTH-1:0] op_in;
  logic [FW-1:0]           dst_in;
  logic [FW-1:0]           src_in [3];
  logic [2:0]              need_in;
  logic [2:0]              ack_in;
  logic [2:0]              rvalid_in;
  logic [DW-1:0]           rdata_in [3];
  logic                    all_done;
  logic [DW-1:0]           result;

  assign op_in     = req_instr[IW-1 -: OPCODE_WIDTH];
  assign src_in[2] = req_instr[4*FW-1 -: FW];
  assign src_in[1] = req_instr[3*FW-1 -: FW];
  assign src_in[0] = req_instr[2*FW-1 -: FW];
  assign dst_in    = req_instr[FW-1:0];

  assign ack_in      = {s2_ack, s1_ack, s0_ack};
  assign rvalid_in   = {s2_rvalid, s1_rvalid, s0_rvalid};
  assign rdata_in[0] = s0_rdata;
  assign rdata_in[1] = s1_rdata;
  assign rdata_in[2] = s2_rdata;

  // Which source ports the incoming opcode needs; zero marks an unknown opcode.
  always_comb begin
    need_in = 3'b000;
    case (op_in)
      OP_MOV:                                 need_in = 3'b001;
      OP_ADD3:                                need_in = 3'b111;
      OP_ADD, OP_SUB, OP_MUL, OP_MAX, OP_MIN: need_in = 3'b011;
      default:                                need_in = 3'b000;
    endcase
  end

  // A port is finished for this cycle when its request has been accepted and
  // its data is either already held or arriving on this edge. Unused ports never
  // set req_q/wait_q, so they count as finished from the start.
  always_comb begin
    all_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (req_q[k] || (wait_q[k] && !rvalid_in[k])) all_done = 1'b0;
    end
  end

  function automatic logic [DW-1:0] lane_alu(input logic [OPCODE_WIDTH-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
    logic [DW-1:0] r;
    logic [31:0]   x, y, z;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = a[32*i +: 32];
      y = b[32*i +: 32];
      z = c[32*i +: 32];
      case (op)
        OP_ADD:  r[32*i +: 32] = x + y;
        OP_SUB:  r[32*i +: 32] = x - y;
        OP_MUL:  r[32*i +: 32] = x * y;
        OP_MAX:  r[32*i +: 32] = ($signed(x) > $signed(y)) ? x : y;
        OP_MIN:  r[32*i +: 32] = ($signed(x) < $signed(y)) ? x : y;
        OP_ADD3: r[32*i +: 32] = x + y + z;
        OP_MOV:  r[32*i +: 32] = x;
        default: r[32*i +: 32] = '0;
      endcase
    end
    return r;
  endfunction

  assign result = lane_alu(op_q, opnd_q[0], opnd_q[1], opnd_q[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_stream_id <= '0;
      op_q          <= '0;
      dst_q         <= '0;
      req_q         <= '0;
      reb_q         <= '1;
      rlast_q       <= '0;
      wait_q        <= '0;
      for (int k = 0; k < 3; k++) begin
        rid_q[k]  <= '0;
        addr_q[k] <= '0;
        opnd_q[k] <= '0;
      end
      d0_req   <= 1'b0;
      d0_wid   <= '0;
      d0_addr  <= '0;
      d0_web   <= 1'b1;
      d0_wlast <= 1'b0;
      d0_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // req_ready comes up one cycle after reset release and stays up in IDLE.
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready     <= 1'b0;
            op_q          <= op_in;
            dst_q         <= dst_in;
            rsp_stream_id <= req_stream_id;
            for (int k = 0; k < 3; k++) begin
              if (need_in[k]) begin
                req_q[k]   <= 1'b1;
                reb_q[k]   <= 1'b0;
                rlast_q[k] <= 1'b1;
                rid_q[k]   <= src_in[k][FW-1 -: BW];
                addr_q[k]  <= src_in[k][AW-1:0];
              end
            end
            if (need_in == 3'b000) begin
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          for (int k = 0; k < 3; k++) begin
            if (req_q[k] && ack_in[k]) begin
              req_q[k]   <= 1'b0;
              reb_q[k]   <= 1'b1;
              rlast_q[k] <= 1'b0;
              wait_q[k]  <= 1'b1;
            end
            if (wait_q[k] && rvalid_in[k]) begin
              opnd_q[k] <= rdata_in[k];
              wait_q[k] <= 1'b0;
            end
          end
          if (all_done) state <= S_EXEC;
        end
        S_EXEC: begin
          d0_wdata <= result;
          d0_req   <= 1'b1;
          d0_wid   <= dst_q[FW-1 -: BW];
          d0_addr  <= dst_q[AW-1:0];
          d0_web   <= 1'b0;
          d0_wlast <= 1'b1;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (d0_ack) begin
            d0_req    <= 1'b0;
            d0_web    <= 1'b1;
            d0_wlast  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign s0_req   = req_q[0];
  assign s0_rid   = rid_q[0];
  assign s0_addr  = addr_q[0];
  assign s0_reb   = reb_q[0];
  assign s0_rlast = rlast_q[0];
  assign s1_req   = req_q[1];
  assign s1_rid   = rid_q[1];
  assign s1_addr  = addr_q[1];
  assign s1_reb   = reb_q[1];
  assign s1_rlast = rlast_q[1];
  assign s2_req   = req_q[2];
  assign s2_rid   = rid_q[2];
  assign s2_addr  = addr_q[2];
  assign s2_reb   = reb_q[2];
  assign s2_rlast = rlast_q[2];

endmodule

// File: tb/tb_vpu_modport.sv
// tb/tb_vpu_modport.sv - testbench for vpu_modport
module tb_vpu_modport;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         rsp_ready;
  logic         d0_ack;
  logic [59:0]  req_instr;
  logic [3:0]   req_stream_id;
  wire          req_ready;
  wire          rsp_valid;
  wire  [3:0]   rsp_stream_id;
  logic [2:0]   s_ack;
  logic [2:0]   s_rvalid;
  logic [511:0] s_rdata [3];
  wire  [2:0]   s_req;
  wire  [2:0]   s_reb;
  wire  [2:0]   s_rlast;
  wire  [2:0]   s_rid  [3];
  wire  [9:0]   s_addr [3];
  wire          d0_req;
  wire          d0_web;
  wire          d0_wlast;
  wire  [2:0]   d0_wid;
  wire  [9:0]   d0_addr;
  wire  [511:0] d0_wdata;

  vpu_modport dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_stream_id(req_stream_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_stream_id(rsp_stream_id),
    .s0_req(s_req[0]), .s0_rid(s_rid[0]), .s0_addr(s_addr[0]), .s0_reb(s_reb[0]),
    .s0_rlast(s_rlast[0]), .s0_ack(s_ack[0]), .s0_rdata(s_rdata[0]), .s0_rvalid(s_rvalid[0]),
    .s1_req(s_req[1]), .s1_rid(s_rid[1]), .s1_addr(s_addr[1]), .s1_reb(s_reb[1]),
    .s1_rlast(s_rlast[1]), .s1_ack(s_ack[1]), .s1_rdata(s_rdata[1]), .s1_rvalid(s_rvalid[1]),
    .s2_req(s_req[2]), .s2_rid(s_rid[2]), .s2_addr(s_addr[2]), .s2_reb(s_reb[2]),
    .s2_rlast(s_rlast[2]), .s2_ack(s_ack[2]), .s2_rdata(s_rdata[2]), .s2_rvalid(s_rvalid[2]),
    .d0_req(d0_req), .d0_wid(d0_wid), .d0_addr(d0_addr), .d0_web(d0_web),
    .d0_wlast(d0_wlast), .d0_wdata(d0_wdata), .d0_ack(d0_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Responder configuration
  int ack_dly [3];
  int rv_dly  [3];
  int d_dly;
  int rsp_dly;
  bit noise;

  // Responder and monitor state
  bit           acked   [3];
  bit           wait_rv [3];
  int           ack_cnt [3];
  int           rv_cnt  [3];
  int           key     [3];
  logic [511:0] mem [int];
  logic [2:0]   req_seen;
  bit           ctl_bad;
  bit           unstable;
  bit           d_active;
  int           d_cnt;
  int           wr_n;
  logic [526:0] d_snap;
  logic [2:0]   wr_wid;
  logic [9:0]   wr_addr;
  logic [511:0] wr_data;
  logic [1:0]   wr_ctl;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference: each lane taken as a plain number and reduced mod 2^32.
  function automatic logic [511:0] model(input logic [7:0] op, input logic [511:0] a,
                                         input logic [511:0] b, input logic [511:0] c);
    logic [511:0]    r;
    longint unsigned x, y, z, v;
    longint unsigned m;
    int              sx, sy;
    r = '0;
    m = 64'h1_0000_0000;
    for (int i = 0; i < 16; i++) begin
      x  = longint'(a[32*i +: 32]);
      y  = longint'(b[32*i +: 32]);
      z  = longint'(c[32*i +: 32]);
      sx = int'(a[32*i +: 32]);
      sy = int'(b[32*i +: 32]);
      case (op)
        8'd1:    v = (x + y) % m;
        8'd2:    v = (x + m - y) % m;
        8'd3:    v = (x * y) % m;
        8'd4:    v = (sx >= sy) ? x : y;
        8'd5:    v = (sx <= sy) ? x : y;
        8'd6:    v = (x + y + z) % m;
        8'd7:    v = x;
        default: v = 0;
      endcase
      r[32*i +: 32] = v[31:0];
    end
    return r;
  endfunction

  function automatic logic [2:0] uses(input logic [7:0] op);
    case (op)
      8'd7:                      return 3'b001;
      8'd6:                      return 3'b111;
      8'd1, 8'd2, 8'd3, 8'd4, 8'd5: return 3'b011;
      default:                   return 3'b000;
    endcase
  endfunction

  // One cycle: observe outputs at the falling edge, then drive the SRAM-side responses.
  task automatic tick();
    @(negedge clk);
    req_seen |= s_req;
    for (int k = 0; k < 3; k++) begin
      if (s_req[k] ? (s_reb[k] !== 1'b0 || s_rlast[k] !== 1'b1)
                   : (s_reb[k] !== 1'b1 || s_rlast[k] !== 1'b0)) ctl_bad = 1;
    end
    d0_ack   = 1'b0;
    s_ack    = '0;
    s_rvalid = '0;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        acked[k] = 0; wait_rv[k] = 0; ack_cnt[k] = 0; rv_cnt[k] = 0;
      end
      d_active = 0;
      return;
    end
    if (d0_req) begin
      if (!d_active) begin
        d_active = 1;
        d_cnt    = 0;
        d_snap   = {d0_wid, d0_addr, d0_web, d0_wlast, d0_wdata};
      end else if ({d0_wid, d0_addr, d0_web, d0_wlast, d0_wdata} !== d_snap) begin
        unstable = 1;
      end
      if (d_cnt >= d_dly) begin
        d0_ack  = 1'b1;
        wr_n++;
        wr_wid  = d0_wid;
        wr_addr = d0_addr;
        wr_data = d0_wdata;
        wr_ctl  = {d0_web, d0_wlast};
      end else begin
        d_cnt++;
      end
    end else begin
      d_active = 0;
      if (noise) d0_ack = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < 3; k++) begin
      if (acked[k]) begin
        acked[k] = 0; wait_rv[k] = 1; rv_cnt[k] = 0;
      end
      if (wait_rv[k]) begin
        rv_cnt[k]++;
        if (rv_cnt[k] >= rv_dly[k]) begin
          s_rvalid[k] = 1'b1;
          s_rdata[k]  = mem.exists(key[k]) ? mem[key[k]] : {16{32'hDEADBEEF}};
          wait_rv[k]  = 0;
        end
      end else if (s_req[k]) begin
        if (ack_cnt[k] >= ack_dly[k]) begin
          s_ack[k]   = 1'b1;
          acked[k]   = 1;
          ack_cnt[k] = 0;
          key[k]     = int'({s_rid[k], s_addr[k]});
        end else begin
          ack_cnt[k]++;
        end
      end else if (noise) begin
        s_ack[k]    = 1'($urandom_range(0, 1));
        s_rvalid[k] = 1'($urandom_range(0, 1));
        s_rdata[k]  = rand512();
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl_low"}, {req_ready, s_req, s_rlast, rsp_valid, d0_req, d0_wlast}, '0);
    chk({tag, "_ctl_high"}, {s_reb, d0_web}, 4'hF);
    chk({tag, "_ids"}, {s_rid[0], s_rid[1], s_rid[2], s_addr[0], s_addr[1], s_addr[2],
                        d0_wid, d0_addr, rsp_stream_id}, '0);
    chk({tag, "_wdata"}, d0_wdata, '0);
  endtask

  task automatic set_delays(input int a, input int r, input int d, input int p);
    for (int k = 0; k < 3; k++) begin
      ack_dly[k] = a; rv_dly[k] = r;
    end
    d_dly = d; rsp_dly = p;
  endtask

  task automatic issue(input string tag, input logic [7:0] op, input logic [12:0] a0,
                       input logic [12:0] a1, input logic [12:0] a2, input logic [12:0] dst,
                       input logic [3:0] sid, input logic [511:0] v0, input logic [511:0] v1,
                       input logic [511:0] v2);
    int n;
    mem.delete();
    mem[int'(a0)] = v0;
    mem[int'(a1)] = v1;
    mem[int'(a2)] = v2;
    req_seen = '0; ctl_bad = 0; unstable = 0; wr_n = 0;
    req_instr     = {op, a2, a1, a0, dst};
    req_stream_id = sid;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_instr = 60'({$urandom, $urandom});
    chk({tag, "_ready_drop"}, req_ready, 1'b0);
  endtask

  task automatic finish_instr(input string tag, input logic [2:0] mask, input logic [12:0] dst,
                              input logic [3:0] sid, input logic [511:0] exp);
    int n;
    bit rdy_busy;
    bit dropped;
    rdy_busy = 0;
    dropped  = 0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      if (req_ready !== 1'b0) rdy_busy = 1;
      rsp_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n++;
    end
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, "_rsp_id"}, rsp_stream_id, sid);
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      if (rsp_valid !== 1'b1) dropped = 1;
      if (req_ready !== 1'b0) rdy_busy = 1;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_clear"}, rsp_valid, 1'b0);
    chk({tag, "_ready_back"}, req_ready, 1'b1);
    chk({tag, "_ready_busy"}, rdy_busy, 1'b0);
    chk({tag, "_rsp_hold"}, dropped, 1'b0);
    chk({tag, "_ports_used"}, req_seen, mask);
    chk({tag, "_src_ctl"}, ctl_bad, 1'b0);
    chk({tag, "_writes"}, wr_n, (mask != 3'b000) ? 1 : 0);
    if (mask != 3'b000) begin
      chk({tag, "_wid"}, wr_wid, dst[12:10]);
      chk({tag, "_waddr"}, wr_addr, dst[9:0]);
      chk({tag, "_wdata"}, wr_data, exp);
      chk({tag, "_wctl"}, wr_ctl, 2'b01);
      chk({tag, "_wstable"}, unstable, 1'b0);
    end
  endtask

  initial begin
    logic [511:0] va, vb, vc, ex;
    logic [12:0]  a0, a1, a2, dst;
    logic [7:0]   op;
    logic [3:0]   sid;
    int           opsel;
    int           rsp_cnt;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; d0_ack = 1'b0;
    req_instr = '0; req_stream_id = '0; s_ack = '0; s_rvalid = '0;
    for (int k = 0; k < 3; k++) s_rdata[k] = '0;
    noise = 0;
    set_delays(0, 1, 0, 0);

    // Reset values, then req_ready one cycle after release
    repeat (3) tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();
    chk("reset_ready_rise", req_ready, 1'b1);

    // ADD: signed overflow wraps to 0x80000000
    set_delays(1, 5, 0, 0);
    a0 = {3'd1, 10'h010}; a1 = {3'd2, 10'h020}; a2 = {3'd0, 10'h3FF}; dst = {3'd3, 10'h030};
    issue("add", 8'h01, a0, a1, a2, dst, 4'd5, {16{32'h7FFFFFFF}}, {16{32'h00000001}}, '0);
    finish_instr("add", 3'b011, dst, 4'd5, {16{32'h80000000}});

    // ADD3 on all-ones lanes
    set_delays(0, 2, 0, 0);
    a0 = {3'd4, 10'h001}; a1 = {3'd5, 10'h002}; a2 = {3'd6, 10'h003}; dst = {3'd7, 10'h3FF};
    issue("add3", 8'h06, a0, a1, a2, dst, 4'd9, {16{32'hFFFFFFFF}}, {16{32'hFFFFFFFF}},
          {16{32'hFFFFFFFF}});
    finish_instr("add3", 3'b111, dst, 4'd9, {16{32'hFFFFFFFD}});

    // MOV uses only source port 0
    va = rand512();
    a0 = {3'd0, 10'h155}; a1 = {3'd1, 10'h0AA}; a2 = {3'd2, 10'h0F0}; dst = {3'd2, 10'h00F};
    issue("mov", 8'h07, a0, a1, a2, dst, 4'd1, va, rand512(), rand512());
    finish_instr("mov", 3'b001, dst, 4'd1, va);

    // Signed MAX / MIN
    a0 = {3'd1, 10'h100}; a1 = {3'd3, 10'h200}; a2 = {3'd5, 10'h300}; dst = {3'd4, 10'h044};
    issue("max", 8'h04, a0, a1, a2, dst, 4'd2, {16{32'hFFFFFFFF}}, {16{32'h00000002}}, '0);
    finish_instr("max", 3'b011, dst, 4'd2, {16{32'h00000002}});
    issue("min", 8'h05, a0, a1, a2, dst, 4'd3, {16{32'hFFFFFFFF}}, {16{32'h00000002}}, '0);
    finish_instr("min", 3'b011, dst, 4'd3, {16{32'hFFFFFFFF}});

    // Write and response backpressure
    set_delays(2, 3, 4, 3);
    va = rand512(); vb = rand512();
    a0 = {3'd6, 10'h011}; a1 = {3'd0, 10'h022}; a2 = {3'd1, 10'h033}; dst = {3'd5, 10'h2A5};
    issue("bp", 8'h02, a0, a1, a2, dst, 4'd12, va, vb, '0);
    finish_instr("bp", 3'b011, dst, 4'd12, model(8'h02, va, vb, '0));

    // Unknown opcode: response only
    set_delays(0, 1, 0, 0);
    issue("unk", 8'hFF, a0, a1, a2, dst, 4'd14, rand512(), rand512(), rand512());
    finish_instr("unk", 3'b000, dst, 4'd14, '0);

    // Reset asserted while an ADD is waiting for read data
    set_delays(0, 20, 0, 0);
    issue("rst_mid", 8'h01, a0, a1, a2, dst, 4'd7, rand512(), rand512(), '0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    repeat (2) tick();
    rst_n = 1'b1;
    req_seen = '0; wr_n = 0; rsp_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid === 1'b1) rsp_cnt++;
    end
    chk("rst_mid_no_rsp", rsp_cnt, 0);
    chk("rst_mid_no_write", wr_n, 0);
    chk("rst_mid_no_req", req_seen, 3'b000);
    chk("rst_mid_ready", req_ready, 1'b1);

    // Randomized instructions with noise on idle ports
    noise = 1;
    for (int t = 0; t < 16; t++) begin
      opsel = $urandom_range(0, 8);
      op = (opsel <= 6) ? 8'(opsel + 1) : ((opsel == 7) ? 8'h00 : 8'h80);
      for (int k = 0; k < 3; k++) begin
        ack_dly[k] = $urandom_range(0, 3);
        rv_dly[k]  = $urandom_range(1, 4);
      end
      d_dly   = $urandom_range(0, 3);
      rsp_dly = $urandom_range(0, 3);
      va = rand512(); vb = rand512(); vc = rand512();
      a0  = 13'($urandom);
      a1  = {a0[12:10] + 3'd1, 10'($urandom)};
      a2  = {a0[12:10] + 3'd2, 10'($urandom)};
      dst = 13'($urandom);
      sid = 4'($urandom);
      ex  = model(op, va, vb, vc);
      issue("rnd", op, a0, a1, a2, dst, sid, va, vb, vc);
      finish_instr("rnd", uses(op), dst, sid, ex);
    end
    noise = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
